cpu_controller: RTL and testbench

Instruction sequencer for the VeriRISC CPU datapath. It steps an 8-phase cycle per instruction and decodes the 3-bit opcode from the instruction register into the datapath strobes that drive the following blocks:
- memory read/write
- address mux select
- IR, AC and PC load/increment
- data-bus enable

It also owns the sticky `HALT` that the top-level `cpu` exports.

---
 rtl/veririsc_pkg.sv | 22 ++
 rtl/cpu_controller.sv | 61 ++++++
 tb/tb_cpu_controller.sv | 96 +++++++++
 3 files changed

// File: rtl/veririsc_pkg.sv
// veririsc_pkg: opcode and phase encodings shared by the VeriRISC controller, ALU and bench
package veririsc_pkg;
  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;
  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction
endpackage

// File: rtl/cpu_controller.sv
// cpu_controller: 8-phase VeriRISC sequencer with sticky HALT; CPU_CONTROLLER_STEP_EN adds single-step input
module cpu_controller
  import veririsc_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
`ifdef CPU_CONTROLLER_STEP_EN
  input  logic       step,
`endif
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       data_e,
  output logic       wr,
  output logic       HALT,
  output logic [2:0] phase
);
  logic [2:0] phase_q, phase_d;
  logic       halt_q, halt_d;
  logic       go, run, alu;
`ifdef CPU_CONTROLLER_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif
  // next phase: freeze when halted, wait in INST_ADDR for go, otherwise advance
  always_comb begin
    halt_d  = halt_q | (phase_q == OP_ADDR && opcode == HLT);
    phase_d = halt_q ? phase_q : (phase_q == INST_ADDR && !go) ? phase_q : phase_q + 3'd1;
  end
  // phase and halt registers with synchronous reset taking priority
  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q <= INST_ADDR;
      halt_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      halt_q  <= halt_d;
    end
  end
  // strobe decode from registered phase; silenced during reset and halt
  always_comb begin
    run    = !RST && !halt_q;
    alu    = is_aluop(opcode);
    sel    = run && phase_q <= IDLE;
    rd     = run && ((phase_q >= INST_FETCH && phase_q <= IDLE) || (phase_q >= OP_FETCH && alu));
    ld_ir  = run && (phase_q == INST_LOAD || phase_q == IDLE);
    inc_pc = run && (phase_q == OP_ADDR || (phase_q == ALU_OP && opcode == SKZ && zero));
    ld_pc  = run && phase_q >= ALU_OP && opcode == JMP;
    ld_ac  = run && phase_q == STORE && alu;
    data_e = run && phase_q >= ALU_OP && opcode == STO;
    wr     = run && phase_q == STORE && opcode == STO;
  end
  assign HALT  = halt_q;
  assign phase = phase_q;
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed checks of phase sequencing, opcode strobes, halt and reset
module tb_cpu_controller;
  import veririsc_pkg::*;
  logic       CLK = 1'b0, RST = 1'b1, zero = 1'b0;
  logic [2:0] opcode = LDA;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, HALT;
  logic [2:0] phase;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  cpu_controller dut (
    .CLK(CLK), .RST(RST),
`ifdef CPU_CONTROLLER_STEP_EN
    .step(1'b1),
`endif
    .opcode(opcode), .zero(zero), .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc),
    .ld_pc(ld_pc), .ld_ac(ld_ac), .data_e(data_e), .wr(wr), .HALT(HALT), .phase(phase)
  );
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask
  task automatic chk(input string tag, input logic [7:0] s_exp, input logic [2:0] p_exp, input logic h_exp);
    logic [11:0] obs, exp;
    obs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, phase, HALT};
    exp = {s_exp, p_exp, h_exp};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed strobes=%b phase=%0d halt=%b expected strobes=%b phase=%0d halt=%b",
             tag, obs[11:4], obs[3:1], obs[0], exp[11:4], exp[3:1], exp[0]);
    end
  endtask
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input logic [7:0] e5, input logic [7:0] e6, input logic [7:0] e7);
    logic [7:0] e [8];
    e = '{8'h80, 8'hC0, 8'hE0, 8'hE0, 8'h10, e5, e6, e7};
    opcode = op;
    zero   = z;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_p%0d", tag, i), e[i], 3'(i), 1'b0);
      tick();
    end
  endtask
  initial begin
    tick();
    tick();
    chk("reset_hold", 8'h00, 3'd0, 1'b0);
    RST = 1'b0;
    #1;
    chk("reset_release", 8'h80, 3'd0, 1'b0);
    run_instr("lda", LDA, 1'b0, 8'h40, 8'h40, 8'h44);
    run_instr("add", ADD, 1'b0, 8'h40, 8'h40, 8'h44);
    run_instr("and", AND, 1'b1, 8'h40, 8'h40, 8'h44);
    run_instr("sto", STO, 1'b0, 8'h00, 8'h02, 8'h03);
    run_instr("skz_z1", SKZ, 1'b1, 8'h00, 8'h10, 8'h00);
    run_instr("skz_z0", SKZ, 1'b0, 8'h00, 8'h00, 8'h00);
    run_instr("jmp", JMP, 1'b0, 8'h00, 8'h08, 8'h08);
    opcode = STO;
    zero   = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("sto_before_abort", 8'h03, 3'd7, 1'b0);
    RST = 1'b1;
    #1;
    chk("abort_no_wr", 8'h00, 3'd7, 1'b0);
    tick();
    RST = 1'b0;
    #1;
    chk("abort_restart", 8'h80, 3'd0, 1'b0);
    opcode = HLT;
    begin
      logic [7:0] e [5];
      e = '{8'h80, 8'hC0, 8'hE0, 8'hE0, 8'h10};
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("hlt_p%0d", i), e[i], 3'(i), 1'b0);
        tick();
      end
    end
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("halted_%0d", i), 8'h00, 3'd5, 1'b1);
      tick();
    end
    RST = 1'b1;
    #1;
    chk("halt_rst_strobes", 8'h00, 3'd5, 1'b1);
    tick();
    chk("halt_rst_cleared", 8'h00, 3'd0, 1'b0);
    RST = 1'b0;
    opcode = LDA;
    #1;
    chk("halt_rst_release", 8'h80, 3'd0, 1'b0);
    tick();
    chk("post_halt_fetch", 8'hC0, 3'd1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
